hazard_unit: RTL and testbench

//  Hazard detection and forwarding control for the 5-stage (F/D/E/M/W) pipelined risc_v core.
//  - Tracks in-flight destination registers for the E, M and W stages in internal shadow registers.
//  - Drives stall, flush and ALU-operand forward selects.
//  - Supports a forwarding mode and a stall-only mode, selected by parameter.
//  - Keeps saturating performance counters of stall and flush cycles.

---
 rtl/hazard_unit.sv | 171 +++++++++++++++++
 tb/tb_hazard_unit.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for a 5-stage F/D/E/M/W pipeline.
// Shadows the E/M/W destination registers and counts stall and flush cycles.
module hazard_unit #(
  parameter int unsigned REG_AW    = 5,
  parameter bit          FWD_EN    = 1'b1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ValidD,
  input  logic [REG_AW-1:0]    Rs1D,
  input  logic [REG_AW-1:0]    Rs2D,
  input  logic [REG_AW-1:0]    RdD,
  input  logic                 RegWriteD,
  input  logic                 MemReadD,
  input  logic                 BranchTakenE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  // E stage shadow
  logic              v_e_q, v_e_d;
  logic [REG_AW-1:0] rs1_e_q, rs1_e_d;
  logic [REG_AW-1:0] rs2_e_q, rs2_e_d;
  logic [REG_AW-1:0] rd_e_q, rd_e_d;
  logic              rw_e_q, rw_e_d;
  logic              ld_e_q, ld_e_d;
  // M stage shadow
  logic              v_m_q, v_m_d;
  logic [REG_AW-1:0] rd_m_q, rd_m_d;
  logic              rw_m_q, rw_m_d;
  // W stage shadow
  logic              v_w_q, v_w_d;
  logic [REG_AW-1:0] rd_w_q, rd_w_d;
  logic              rw_w_q, rw_w_d;

  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic hit_e, hit_m, hit_w, hz;

  // x0 is hard-wired to zero, so a write to it never produces a hazard.
  function automatic logic dest_match(input logic              v,
                                      input logic              rw,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] rs);
    return v & rw & (rd != '0) & (rd == rs);
  endfunction

  always_comb begin
    hit_e = dest_match(v_e_q, rw_e_q, rd_e_q, Rs1D) | dest_match(v_e_q, rw_e_q, rd_e_q, Rs2D);
    hit_m = dest_match(v_m_q, rw_m_q, rd_m_q, Rs1D) | dest_match(v_m_q, rw_m_q, rd_m_q, Rs2D);
    hit_w = dest_match(v_w_q, rw_w_q, rd_w_q, Rs1D) | dest_match(v_w_q, rw_w_q, rd_w_q, Rs2D);
    if (FWD_EN) begin
      hz = ValidD & ld_e_q & hit_e;
    end else begin
      // No write-through register file: wait until the producer has left W.
      hz = ValidD & (hit_e | hit_m | hit_w);
    end
  end

  // A taken branch means D holds a wrong-path instruction, so flushing beats stalling.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (BranchTakenE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = hz;
      StallD = hz;
      FlushE = hz;
    end
  end

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (FWD_EN) begin
      if (dest_match(v_m_q, rw_m_q, rd_m_q, rs1_e_q)) begin
        ForwardAE = 2'b10;
      end else if (dest_match(v_w_q, rw_w_q, rd_w_q, rs1_e_q)) begin
        ForwardAE = 2'b01;
      end
      if (dest_match(v_m_q, rw_m_q, rd_m_q, rs2_e_q)) begin
        ForwardBE = 2'b10;
      end else if (dest_match(v_w_q, rw_w_q, rd_w_q, rs2_e_q)) begin
        ForwardBE = 2'b01;
      end
    end
  end

  always_comb begin
    v_e_d   = ValidD & ~FlushE;
    rs1_e_d = Rs1D;
    rs2_e_d = Rs2D;
    rd_e_d  = RdD;
    rw_e_d  = RegWriteD;
    ld_e_d  = MemReadD;

    v_m_d   = v_e_q;
    rd_m_d  = rd_e_q;
    rw_m_d  = rw_e_q;

    v_w_d   = v_m_q;
    rd_w_d  = rd_m_q;
    rw_w_d  = rw_m_q;

    stall_cnt_d = stall_cnt_q;
    if (StallD && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (BranchTakenE && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_e_q       <= 1'b0;
      rs1_e_q     <= '0;
      rs2_e_q     <= '0;
      rd_e_q      <= '0;
      rw_e_q      <= 1'b0;
      ld_e_q      <= 1'b0;
      v_m_q       <= 1'b0;
      rd_m_q      <= '0;
      rw_m_q      <= 1'b0;
      v_w_q       <= 1'b0;
      rd_w_q      <= '0;
      rw_w_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      v_e_q       <= v_e_d;
      rs1_e_q     <= rs1_e_d;
      rs2_e_q     <= rs2_e_d;
      rd_e_q      <= rd_e_d;
      rw_e_q      <= rw_e_d;
      ld_e_q      <= ld_e_d;
      v_m_q       <= v_m_d;
      rd_m_q      <= rd_m_d;
      rw_m_q      <= rw_m_d;
      v_w_q       <= v_w_d;
      rd_w_q      <= rd_w_d;
      rw_w_q      <= rw_w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

  stall_flush_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(StallD && FlushD));
  no_forward_when_disabled: assert property (@(posedge clk)
    !FWD_EN |-> (ForwardAE == 2'b00 && ForwardBE == 2'b00));

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed pipeline scenarios plus randomized traffic checked
// against an in-flight instruction list model. Instances: 0 forwarding, 1 stall-only, 2 narrow counters.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       ValidD, RegWriteD, MemReadD, BranchTakenE;
  logic [4:0] Rs1D, Rs2D, RdD;

  logic       stf [3];
  logic       std [3];
  logic       fld [3];
  logic       fle [3];
  logic [1:0] fa  [3];
  logic [1:0] fb  [3];
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(5), .FWD_EN(1'b1), .CNT_WIDTH(16)) u_fwd (
    .clk(clk), .rst(rst), .ValidD(ValidD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemReadD(MemReadD), .BranchTakenE(BranchTakenE),
    .StallF(stf[0]), .StallD(std[0]), .FlushD(fld[0]), .FlushE(fle[0]),
    .ForwardAE(fa[0]), .ForwardBE(fb[0]), .stall_count(sc0), .flush_count(fc0)
  );

  hazard_unit #(.REG_AW(5), .FWD_EN(1'b0), .CNT_WIDTH(16)) u_stl (
    .clk(clk), .rst(rst), .ValidD(ValidD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemReadD(MemReadD), .BranchTakenE(BranchTakenE),
    .StallF(stf[1]), .StallD(std[1]), .FlushD(fld[1]), .FlushE(fle[1]),
    .ForwardAE(fa[1]), .ForwardBE(fb[1]), .stall_count(sc1), .flush_count(fc1)
  );

  hazard_unit #(.REG_AW(5), .FWD_EN(1'b0), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .ValidD(ValidD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemReadD(MemReadD), .BranchTakenE(BranchTakenE),
    .StallF(stf[2]), .StallD(std[2]), .FlushD(fld[2]), .FlushE(fle[2]),
    .ForwardAE(fa[2]), .ForwardBE(fb[2]), .stall_count(sc2), .flush_count(fc2)
  );

  task automatic drive_d(input bit v, input int rs1, input int rs2, input int rd,
                         input bit rw, input bit ld);
    ValidD    = v;
    Rs1D      = 5'(rs1);
    Rs2D      = 5'(rs2);
    RdD       = 5'(rd);
    RegWriteD = rw;
    MemReadD  = ld;
  endtask

  task automatic nop_d();
    drive_d(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    BranchTakenE = 1'b0;
    nop_d();
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({stf[i], std[i], fld[i], fle[i], fa[i], fb[i]} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_outputs inst%0d: got %b want 00000000", i,
                 {stf[i], std[i], fld[i], fle[i], fa[i], fb[i]});
      end
    end
    n_checks++;
    if ({sc0, fc0, sc1, fc1, sc2, fc2} !== '0) begin
      n_fail++;
      $display("FAIL reset_counts: got %0d %0d %0d %0d %0d %0d want all 0",
               sc0, fc0, sc1, fc1, sc2, fc2);
    end
    // Build up a load-use stall, then reset mid-stall: tracking and counts must vanish.
    next_cycle();
    drive_d(1'b1, 1, 0, 6, 1'b1, 1'b1);
    next_cycle();
    drive_d(1'b1, 1, 6, 7, 1'b1, 1'b0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    settle();
    n_checks++;
    if ({std[0], std[1], sc0, sc1} !== 34'h0) begin
      n_fail++;
      $display("FAIL reset_discard: got stallD %b%b counts %0d %0d want 00 0 0",
               std[0], std[1], sc0, sc1);
    end
  endtask

  task automatic test_forward();
    do_reset();
    drive_d(1'b1, 1, 2, 5, 1'b1, 1'b0);   // add x5,x1,x2
    next_cycle();
    drive_d(1'b1, 5, 3, 6, 1'b1, 1'b0);   // add x6,x5,x3
    settle();
    n_checks++;
    if (std[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_no_stall: got StallD %b want 0", std[0]);
    end
    next_cycle();
    drive_d(1'b1, 5, 4, 7, 1'b1, 1'b0);   // add x7,x5,x4
    settle();
    n_checks++;
    if ({std[0], fa[0], fb[0]} !== 5'b0_10_00) begin
      n_fail++;
      $display("FAIL fwd_from_m: got stall %b A %b B %b want 0 10 00", std[0], fa[0], fb[0]);
    end
    next_cycle();
    nop_d();
    settle();
    n_checks++;
    if ({fa[0], fb[0]} !== 4'b01_00) begin
      n_fail++;
      $display("FAIL fwd_from_w: got A %b B %b want 01 00", fa[0], fb[0]);
    end
    n_checks++;
    if (sc0 !== 16'd0) begin
      n_fail++;
      $display("FAIL fwd_stall_count: got %0d want 0", sc0);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_d(1'b1, 1, 0, 6, 1'b1, 1'b1);   // lw x6,0(x1)
    next_cycle();
    drive_d(1'b1, 1, 6, 7, 1'b1, 1'b0);   // add x7,x1,x6
    settle();
    n_checks++;
    if ({stf[0], std[0], fld[0], fle[0]} !== 4'b1101) begin
      n_fail++;
      $display("FAIL load_use_stall: got F/D/fD/fE %b want 1101",
               {stf[0], std[0], fld[0], fle[0]});
    end
    next_cycle();
    settle();
    n_checks++;
    if ({std[0], sc0} !== {1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL load_use_one_cycle: got StallD %b count %0d want 0 1", std[0], sc0);
    end
    next_cycle();
    nop_d();
    settle();
    n_checks++;
    if ({fa[0], fb[0]} !== 4'b00_01) begin
      n_fail++;
      $display("FAIL load_use_fwd: got A %b B %b want 00 01", fa[0], fb[0]);
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    drive_d(1'b1, 1, 0, 6, 1'b1, 1'b1);
    next_cycle();
    drive_d(1'b1, 1, 6, 7, 1'b1, 1'b0);
    BranchTakenE = 1'b1;
    settle();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({stf[i], std[i], fld[i], fle[i]} !== 4'b0011) begin
        n_fail++;
        $display("FAIL branch_flush inst%0d: got F/D/fD/fE %b want 0011", i,
                 {stf[i], std[i], fld[i], fle[i]});
      end
    end
    next_cycle();
    BranchTakenE = 1'b0;
    nop_d();
    settle();
    n_checks++;
    if ({fc0, sc0} !== {16'd1, 16'd0}) begin
      n_fail++;
      $display("FAIL branch_counts: got flush %0d stall %0d want 1 0", fc0, sc0);
    end
  endtask

  task automatic test_stall_only();
    do_reset();
    drive_d(1'b1, 1, 2, 5, 1'b1, 1'b0);
    next_cycle();
    drive_d(1'b1, 5, 3, 6, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      settle();
      n_checks++;
      if ({std[1], fa[1], fb[1], std[0]} !== 6'b1_00_00_0) begin
        n_fail++;
        $display("FAIL stall_only_c%0d: got stallD %b A %b B %b fwd-inst stall %b want 1 00 00 0",
                 k, std[1], fa[1], fb[1], std[0]);
      end
      next_cycle();
    end
    settle();
    n_checks++;
    if ({std[1], sc1} !== {1'b0, 16'd3}) begin
      n_fail++;
      $display("FAIL stall_only_release: got StallD %b count %0d want 0 3", std[1], sc1);
    end
  endtask

  task automatic test_x0_and_invalid();
    do_reset();
    drive_d(1'b1, 1, 0, 0, 1'b1, 1'b1);   // load into x0
    next_cycle();
    drive_d(1'b1, 0, 0, 1, 1'b1, 1'b0);   // add x1,x0,x0
    settle();
    n_checks++;
    if ({std[0], std[1]} !== 2'b00) begin
      n_fail++;
      $display("FAIL x0_no_stall: got %b%b want 00", std[0], std[1]);
    end
    next_cycle();
    nop_d();
    settle();
    n_checks++;
    if ({fa[0], fb[0]} !== 4'b0000) begin
      n_fail++;
      $display("FAIL x0_no_forward: got A %b B %b want 00 00", fa[0], fb[0]);
    end
    do_reset();
    drive_d(1'b1, 1, 0, 6, 1'b1, 1'b1);
    next_cycle();
    drive_d(1'b0, 6, 6, 7, 1'b1, 1'b0);
    settle();
    n_checks++;
    if ({std[0], std[1]} !== 2'b00) begin
      n_fail++;
      $display("FAIL invalid_d_no_stall: got %b%b want 00", std[0], std[1]);
    end
  endtask

  task automatic test_saturate();
    int stalls = 0;
    do_reset();
    drive_d(1'b1, 5, 0, 5, 1'b1, 1'b0);   // add x5,x5,x0 repeated: chain of dependencies
    for (int k = 0; k < 40; k++) begin
      settle();
      if (std[1] === 1'b1) stalls++;
      next_cycle();
    end
    settle();
    n_checks++;
    if (stalls != 30) begin
      n_fail++;
      $display("FAIL sat_stall_cycles: got %0d want 30", stalls);
    end
    n_checks++;
    if (sc2 !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_hold: got %0d want 15", sc2);
    end
    n_checks++;
    if (sc1 !== 16'(stalls)) begin
      n_fail++;
      $display("FAIL sat_wide_count: got %0d want %0d", sc1, stalls);
    end
  endtask

  // Reference model: list of in-flight instructions, index 0 = E, 1 = M, 2 = W.
  typedef struct packed {
    bit       v;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit [4:0] rd;
    bit       rw;
    bit       ld;
  } ins_t;

  ins_t pipe [2][3];
  int   exp_sc [3];
  int   exp_fc [3];

  function automatic bit writes(input ins_t p, input bit [4:0] r);
    return p.v && p.rw && (p.rd != 5'd0) && (p.rd == r);
  endfunction

  function automatic bit model_hz(input int m, input ins_t d);
    bit [4:0] srcs [2];
    if (!d.v) return 1'b0;
    srcs[0] = d.rs1;
    srcs[1] = d.rs2;
    for (int s = 0; s < 2; s++) begin
      if (m == 0) begin
        if (pipe[0][0].ld && writes(pipe[0][0], srcs[s])) return 1'b1;
      end else begin
        for (int k = 0; k < 3; k++) if (writes(pipe[1][k], srcs[s])) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit [1:0] model_fwd(input int m, input bit [4:0] rs);
    if (m == 1) return 2'b00;
    if (writes(pipe[0][1], rs)) return 2'b10;
    if (writes(pipe[0][2], rs)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_random();
    ins_t d;
    bit   br;
    bit   hold = 1'b0;
    bit   hzv [2];
    do_reset();
    for (int m = 0; m < 2; m++) for (int k = 0; k < 3; k++) pipe[m][k] = '0;
    for (int i = 0; i < 3; i++) begin
      exp_sc[i] = 0;
      exp_fc[i] = 0;
    end
    d = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold) begin
        d.v   = ($urandom_range(0, 7) != 0);
        d.rs1 = 5'($urandom_range(0, 7));
        d.rs2 = 5'($urandom_range(0, 7));
        d.rd  = 5'($urandom_range(0, 7));
        d.rw  = ($urandom_range(0, 3) != 0);
        d.ld  = ($urandom_range(0, 2) == 0);
      end
      br  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 63) != 0);
      drive_d(d.v, int'(d.rs1), int'(d.rs2), int'(d.rd), d.rw, d.ld);
      BranchTakenE = br;
      settle();
      for (int m = 0; m < 2; m++) hzv[m] = model_hz(m, d);
      for (int i = 0; i < 3; i++) begin
        int   m = (i == 0) ? 0 : 1;
        logic [3:0] exp_ctl = br ? 4'b0011 : {hzv[m], hzv[m], 1'b0, hzv[m]};
        logic [3:0] exp_fw  = {model_fwd(m, pipe[m][0].rs1), model_fwd(m, pipe[m][0].rs2)};
        int   got_sc = (i == 0) ? int'(sc0) : (i == 1) ? int'(sc1) : int'(sc2);
        int   got_fc = (i == 0) ? int'(fc0) : (i == 1) ? int'(fc1) : int'(fc2);
        n_checks++;
        if ({stf[i], std[i], fld[i], fle[i]} !== exp_ctl) begin
          n_fail++;
          $display("FAIL rnd_ctl inst%0d cyc%0d: got %b want %b", i, cyc,
                   {stf[i], std[i], fld[i], fle[i]}, exp_ctl);
        end
        n_checks++;
        if ({fa[i], fb[i]} !== exp_fw) begin
          n_fail++;
          $display("FAIL rnd_fwd inst%0d cyc%0d: got %b want %b", i, cyc, {fa[i], fb[i]}, exp_fw);
        end
        n_checks++;
        if (got_sc != exp_sc[i] || got_fc != exp_fc[i]) begin
          n_fail++;
          $display("FAIL rnd_cnt inst%0d cyc%0d: got %0d/%0d want %0d/%0d", i, cyc,
                   got_sc, got_fc, exp_sc[i], exp_fc[i]);
        end
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!rst) begin
          for (int k = 0; k < 3; k++) pipe[m][k].v = 1'b0;
        end else begin
          pipe[m][2]   = pipe[m][1];
          pipe[m][1]   = pipe[m][0];
          pipe[m][0]   = d;
          pipe[m][0].v = d.v && !(br || hzv[m]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        int m   = (i == 0) ? 0 : 1;
        int max = (i == 2) ? 15 : 65535;
        if (!rst) begin
          exp_sc[i] = 0;
          exp_fc[i] = 0;
        end else begin
          if (!br && hzv[m] && exp_sc[i] < max) exp_sc[i]++;
          if (br && exp_fc[i] < max) exp_fc[i]++;
        end
      end
      #1;
      hold = rst && !br && hzv[(cyc < 200) ? 0 : 1];
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    BranchTakenE = 1'b0;
    nop_d();
    test_reset();
    test_forward();
    test_load_use();
    test_branch_flush();
    test_stall_only();
    test_x0_and_invalid();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
